game_sequencer: RTL and testbench

Move sequencer for the tic-tac-toe turn/board datapath. It takes the nine cell switches, detects individual presses, checks each press against the current board, and issues one-hot move strobes with the current player's turn. It also alternates turns, clears the board, and latches the outcome: win, draw, or forfeit on inactivity. It sits between the switch synchronizers and the turn/board datapath, and its status outputs drive the display driver.

---
 rtl/game_sequencer_if.sv | 25 ++
 rtl/game_sequencer.sv | 125 ++++++++++++
 tb/tb_game_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: switch/board inputs and move/status outputs of the move sequencer
interface game_sequencer_if;
  logic [8:0] sw;
  logic new_game;
  logic [17:0] p;
  logic p1_win;
  logic p2_win;
  logic [8:0] s_out;
  logic turn;
  logic clr;
  logic mv_valid;
  logic illegal;
  logic game_over;
  logic [1:0] winner;
  logic forfeit;
  logic [3:0] move_cnt;
  modport master (
    output sw, new_game, p, p1_win, p2_win,
    input s_out, turn, clr, mv_valid, illegal, game_over, winner, forfeit, move_cnt
  );
  modport slave (
    input sw, new_game, p, p1_win, p2_win,
    output s_out, turn, clr, mv_valid, illegal, game_over, winner, forfeit, move_cnt
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: tic-tac-toe move sequencer with press detection, turn control and outcome latch
module game_sequencer #(
  parameter int TIMEOUT = 0,
  parameter int TO_W = 32
) (
  input logic clk,
  input logic reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [2:0] {CLEAR, WAIT, APPLY, SETTLE, CHECK, OVER} state_t;
  state_t state_q, state_d;
  logic [8:0] sw_q, rise, occ, mv_sel_q, mv_sel_d, s_out_q, s_out_d;
  logic turn_q, turn_d, forfeit_q, forfeit_d, illegal_q, illegal_d;
  logic mv_valid_q, mv_valid_d, clr_q, clr_d, game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] move_cnt_q, move_cnt_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic legal, bad, tmo, mover_win, other_win;
  always_comb begin
    for (int k = 0; k < 9; k++) occ[k] = |bus.p[2*k +: 2];
    rise = bus.sw & ~sw_q;
    legal = rise != '0 && (rise & (rise - 9'd1)) == '0 && (rise & occ) == '0;
    bad = rise != '0 && !legal;
    tmo = TIMEOUT != 0 && cnt_q == TO_W'(TIMEOUT - 1);
    mover_win = turn_q ? bus.p2_win : bus.p1_win;
    other_win = turn_q ? bus.p1_win : bus.p2_win;
    state_d = state_q;
    mv_sel_d = mv_sel_q;
    turn_d = turn_q;
    winner_d = winner_q;
    forfeit_d = forfeit_q;
    move_cnt_d = move_cnt_q;
    cnt_d = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      CLEAR: state_d = WAIT;
      WAIT: begin
        if (legal) begin
          mv_sel_d = rise;
          state_d = APPLY;
        end else if (tmo) begin
          winner_d = {~turn_q, turn_q};
          forfeit_d = 1'b1;
          state_d = OVER;
        end else begin
          illegal_d = bad;
          cnt_d = (rise == '0 && TIMEOUT != 0) ? cnt_q + TO_W'(1) : cnt_q;
        end
      end
      APPLY: state_d = SETTLE;
      SETTLE: begin
        move_cnt_d = move_cnt_q == 4'd9 ? 4'd9 : move_cnt_q + 4'd1;
        state_d = CHECK;
      end
      CHECK: begin
        if (mover_win) begin
          winner_d = {turn_q, ~turn_q};
          state_d = OVER;
        end else if (other_win) begin
          winner_d = {~turn_q, turn_q};
          state_d = OVER;
        end else if (move_cnt_q == 4'd9) begin
          winner_d = 2'b00;
          state_d = OVER;
        end else begin
          turn_d = ~turn_q;
          cnt_d = '0;
          state_d = WAIT;
        end
      end
      OVER: state_d = bus.new_game ? CLEAR : OVER;
      default: state_d = CLEAR;
    endcase
    if (state_d == CLEAR) begin
      turn_d = 1'b0;
      winner_d = 2'b00;
      forfeit_d = 1'b0;
      move_cnt_d = 4'd0;
      cnt_d = '0;
    end
    s_out_d = state_d == APPLY ? mv_sel_d : '0;
    mv_valid_d = state_d == APPLY;
    clr_d = state_d == CLEAR;
    game_over_d = state_d == OVER;
  end
  always_ff @(posedge clk) begin
    sw_q <= bus.sw;
    if (reset) begin
      state_q <= CLEAR;
      mv_sel_q <= '0;
      turn_q <= 1'b0;
      winner_q <= 2'b00;
      forfeit_q <= 1'b0;
      move_cnt_q <= 4'd0;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      s_out_q <= '0;
      mv_valid_q <= 1'b0;
      clr_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_sel_q <= mv_sel_d;
      turn_q <= turn_d;
      winner_q <= winner_d;
      forfeit_q <= forfeit_d;
      move_cnt_q <= move_cnt_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      s_out_q <= s_out_d;
      mv_valid_q <= mv_valid_d;
      clr_q <= clr_d;
      game_over_q <= game_over_d;
    end
  end
  assign bus.s_out = s_out_q;
  assign bus.turn = turn_q;
  assign bus.clr = clr_q;
  assign bus.mv_valid = mv_valid_q;
  assign bus.illegal = illegal_q;
  assign bus.game_over = game_over_q;
  assign bus.winner = winner_q;
  assign bus.forfeit = forfeit_q;
  assign bus.move_cnt = move_cnt_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and random play checked against a game-rule model of the sequencer
module tb_game_sequencer;
  localparam int TO = 20;
  localparam logic [8:0] LINES [8] = '{9'h1c0, 9'h038, 9'h007, 9'h124, 9'h092, 9'h049, 9'h111, 9'h054};
  typedef struct packed {
    logic clear, over;
    logic [1:0] ph;
    logic [8:0] sel, swq;
    logic turn;
    logic [3:0] cnt;
    logic [1:0] win;
    logic ff;
    logic [7:0] idle;
    logic ill;
  } mdl_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  logic [1:0] board [9];
  int compared = 0, failed = 0, cyc = 0;
  int ap_cnt = 0, ill_cnt = 0, clr_cnt = 0;
  logic [8:0] sq [$];
  logic tq [$];
  mdl_t m = '0;
  game_sequencer_if bus ();
  game_sequencer #(.TIMEOUT(TO), .TO_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [8:0] who(input logic [17:0] p, input logic [1:0] v);
    logic [8:0] b;
    for (int k = 0; k < 9; k++) b[k] = p[2*k +: 2] == v;
    return b;
  endfunction
  function automatic logic has_line(input logic [8:0] b);
    for (int i = 0; i < 8; i++) if ((b & LINES[i]) == LINES[i]) return 1'b1;
    return 1'b0;
  endfunction
  always_comb for (int k = 0; k < 9; k++) bus.p[2*k +: 2] = board[k];
  assign bus.p1_win = has_line(who(bus.p, 2'd1));
  assign bus.p2_win = has_line(who(bus.p, 2'd2));
  // ph counts cycles since an accepted press: 1 strobe, 2 idle, 3 outcome decision
  function automatic mdl_t step(input mdl_t s, input logic rst, input logic [8:0] sw, input logic ng, input logic [17:0] p);
    logic [8:0] r;
    logic w1, w2, wm, wo;
    r = sw & ~s.swq;
    s.swq = sw;
    s.ill = 1'b0;
    w1 = has_line(who(p, 2'd1));
    w2 = has_line(who(p, 2'd2));
    wm = s.turn ? w2 : w1;
    wo = s.turn ? w1 : w2;
    if (rst || (s.over && ng)) begin
      s.clear = 1'b1; s.over = 1'b0; s.ph = 2'd0; s.turn = 1'b0;
      s.cnt = 4'd0; s.win = 2'd0; s.ff = 1'b0; s.idle = 8'd0;
    end else if (s.clear) s.clear = 1'b0;
    else if (!s.over) begin
      if (s.ph == 2'd1) s.ph = 2'd2;
      else if (s.ph == 2'd2) begin
        s.ph = 2'd3;
        if (s.cnt < 4'd9) s.cnt = s.cnt + 4'd1;
      end else if (s.ph == 2'd3) begin
        s.ph = 2'd0;
        if (wm) begin s.over = 1'b1; s.win = s.turn ? 2'd2 : 2'd1; end
        else if (wo) begin s.over = 1'b1; s.win = s.turn ? 2'd1 : 2'd2; end
        else if (s.cnt == 4'd9) begin s.over = 1'b1; s.win = 2'd0; end
        else begin s.turn = ~s.turn; s.idle = 8'd0; end
      end else if ($countones(r) == 1 && (r & ~who(p, 2'd0)) == '0) begin
        s.sel = r; s.ph = 2'd1;
      end else if (int'(s.idle) == TO - 1) begin
        s.over = 1'b1; s.ff = 1'b1; s.win = s.turn ? 2'd1 : 2'd2;
      end else if (r != '0) s.ill = 1'b1;
      else s.idle = s.idle + 8'd1;
    end
    return s;
  endfunction
  always @(posedge clk) m <= step(m, reset, bus.sw, bus.new_game, bus.p);
  always @(negedge clk) begin
    if (bus.clr) for (int k = 0; k < 9; k++) board[k] <= 2'd0;
    else if (bus.mv_valid) for (int k = 0; k < 9; k++) if (bus.s_out[k]) board[k] <= bus.turn ? 2'd2 : 2'd1;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    logic [20:0] act, exp;
    cyc++;
    act = {bus.s_out, bus.turn, bus.clr, bus.mv_valid, bus.illegal, bus.game_over, bus.winner, bus.forfeit, bus.move_cnt};
    exp = {m.ph == 2'd1 ? m.sel : 9'd0, m.turn, m.clear, m.ph == 2'd1, m.ill, m.over, m.win, m.ff, m.cnt};
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL outputs cycle %0d: got %h want %h", cyc, act, exp);
    end
    if (bus.mv_valid) begin ap_cnt++; sq.push_back(bus.s_out); tq.push_back(bus.turn); end
    if (bus.illegal) ill_cnt++;
    if (bus.clr) clr_cnt++;
  end
  task automatic press(input int k);
    @(negedge clk) bus.sw[k] = 1'b1;
    @(negedge clk) bus.sw[k] = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk) begin reset = 1'b1; bus.sw = '0; bus.new_game = 1'b0; end
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic start_new();
    @(negedge clk) bus.new_game = 1'b1;
    @(negedge clk) bus.new_game = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_over(input int lim);
    int n = 0;
    while (!bus.game_over && n < lim) begin @(negedge clk); n++; end
    check("wait_over", 32'(bus.game_over), 32'd1);
  endtask
  initial begin
    int a, i, c, n;
    logic [4:0] ts;
    bus.sw = '0;
    bus.new_game = 1'b0;
    for (int k = 0; k < 9; k++) board[k] = 2'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_clr", 32'(bus.clr), 32'd1);
    check("reset_cnt", 32'(bus.move_cnt), 32'd0);
    reset = 1'b0;
    sq.delete(); tq.delete(); a = ap_cnt;
    foreach (LINES[j]) if (j < 5) press(j == 0 ? 8 : j == 1 ? 4 : j == 2 ? 7 : j == 3 ? 3 : 6);
    check("row_applies", 32'(ap_cnt - a), 32'd5);
    check("row_s0", 32'(sq[0]), 32'h100);
    check("row_s1", 32'(sq[1]), 32'h010);
    for (int j = 0; j < 5; j++) ts[4-j] = tq[j];
    check("row_turns", 32'(ts), 32'b01010);
    check("row_winner", 32'(bus.winner), 32'd1);
    check("row_cnt", 32'(bus.move_cnt), 32'd5);
    check("row_over", 32'(bus.game_over), 32'd1);
    start_new();
    a = ap_cnt;
    press(4);
    i = ill_cnt;
    press(4);
    check("dup_illegal", 32'(ill_cnt - i), 32'd1);
    check("dup_applies", 32'(ap_cnt - a), 32'd1);
    check("dup_turn", 32'(bus.turn), 32'd1);
    i = ill_cnt;
    @(negedge clk) bus.sw[1:0] = 2'b11;
    repeat (2) @(negedge clk);
    check("pair_illegal", 32'(ill_cnt - i), 32'd1);
    a = ap_cnt;
    press(2);
    check("held_applies", 32'(ap_cnt - a), 32'd1);
    check("held_sel", 32'(sq[sq.size()-1]), 32'h004);
    bus.sw = '0;
    do_reset();
    a = ap_cnt;
    foreach (LINES[j]) press(j == 0 ? 8 : j == 1 ? 7 : j == 2 ? 6 : j == 3 ? 4 : j == 4 ? 5 : j == 5 ? 3 : j == 6 ? 1 : 2);
    press(0);
    check("draw_applies", 32'(ap_cnt - a), 32'd9);
    check("draw_winner", 32'(bus.winner), 32'd0);
    check("draw_cnt", 32'(bus.move_cnt), 32'd9);
    check("draw_over", 32'(bus.game_over), 32'd1);
    c = clr_cnt;
    start_new();
    check("restart_clr", 32'(clr_cnt - c), 32'd1);
    check("restart_status", {bus.game_over, bus.winner, bus.forfeit, bus.turn, bus.move_cnt}, 32'd0);
    @(negedge clk) bus.sw[4] = 1'b1;
    n = 0;
    do begin @(negedge clk) bus.sw[4] = 1'b0; n++; end while (!bus.game_over && n < 80);
    check("timeout_latency", 32'(n), 32'd24);
    check("timeout_winner", 32'(bus.winner), 32'd1);
    check("timeout_forfeit", 32'(bus.forfeit), 32'd1);
    start_new();
    @(negedge clk) bus.sw[5] = 1'b1;
    @(negedge clk) begin bus.sw[5] = 1'b0; check("apply_seen", 32'(bus.mv_valid), 32'd1); reset = 1'b1; end
    @(negedge clk) begin
      check("reset_apply_sout", 32'(bus.s_out), 32'd0);
      check("reset_apply_clr", 32'(bus.clr), 32'd1);
      reset = 1'b0;
    end
    wait_over(60);
    check("p1_timeout_winner", 32'(bus.winner), 32'd2);
    a = ap_cnt; i = ill_cnt;
    @(negedge clk) bus.sw[3] = 1'b1;
    repeat (3) @(negedge clk);
    bus.sw[3] = 1'b0;
    check("over_press_illegal", 32'(ill_cnt - i), 32'd0);
    check("over_press_apply", 32'(ap_cnt - a), 32'd0);
    check("over_hold", 32'(bus.game_over), 32'd1);
    repeat (3000) @(negedge clk) begin
      if ($urandom_range(0, 3) == 0) bus.sw = bus.sw ^ (9'd1 << $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) bus.sw = bus.sw ^ (9'd1 << $urandom_range(0, 8));
      bus.new_game = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 299) == 0;
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
